pipe_hazard_ctrl: RTL

- Hazard, forwarding and stall/flush controller for the 5-stage successor of the single-cycle pd core (F, D, E, M, W).
- Mirrors the destination/source register bookkeeping of every in-flight instruction in its own shadow pipeline.
- Generates operand-forward selects for the execute stage, load-use interlocks, taken-branch flushes, and multi-cycle memory freezes.
- Sits beside the datapath pipeline registers and drives their enable/clear inputs.

---
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Hazard/forward/stall/flush/freeze control for a 5-stage pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int RWIDTH   = 5,
    parameter bit FWD_EN   = 1'b1,
    parameter int LOAD_LAT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid_i,
    input  logic [RWIDTH-1:0] d_rs1_i,
    input  logic [RWIDTH-1:0] d_rs2_i,
    input  logic              d_rs1_used_i,
    input  logic              d_rs2_used_i,
    input  logic [RWIDTH-1:0] d_rd_i,
    input  logic              d_regwren_i,
    input  logic              d_memren_i,
    input  logic              e_brtaken_i,
    output logic              stall_fd_o,
    output logic              flush_fd_o,
    output logic              bubble_de_o,
    output logic              freeze_o,
    output logic [1:0]        fwd_rs1_sel_o,
    output logic [1:0]        fwd_rs2_sel_o
);

    localparam logic [1:0] c_sel_rf  = 2'b00;
    localparam logic [1:0] c_sel_m   = 2'b01;
    localparam logic [1:0] c_sel_w   = 2'b10;
    localparam logic [3:0] c_lat     = LOAD_LAT[3:0];

    typedef struct packed {
        logic              valid;
        logic [RWIDTH-1:0] rd;
        logic              wr;
        logic              ld;
    } stage_t;

    typedef struct packed {
        stage_t            s;
        logic [RWIDTH-1:0] rs1;
        logic [RWIDTH-1:0] rs2;
        logic              u1;
        logic              u2;
    } ex_t;

    // W only needs enough to identify a writeback producer.
    typedef struct packed {
        logic              valid;
        logic [RWIDTH-1:0] rd;
        logic              wr;
    } wb_t;

    ex_t        e_q, e_d;
    stage_t     m_q, m_d;
    wb_t        w_q, w_d;
    logic [3:0] cnt_q, cnt_d;

    logic       w_freeze;
    logic       w_br;
    logic       w_hazard;
    logic       w_d_u1;
    logic       w_d_u2;
    logic [1:0] w_sel1;
    logic [1:0] w_sel2;

    function automatic logic f_match(input logic v, input logic wr,
                                     input logic [RWIDTH-1:0] rd,
                                     input logic [RWIDTH-1:0] src,
                                     input logic used);
        return v && wr && (rd == src) && (src != '0) && used;
    endfunction

    assign w_freeze = (cnt_q != 4'd0) && m_q.valid && m_q.ld;
    assign w_br     = e_q.s.valid && e_brtaken_i;
    assign w_d_u1   = d_valid_i && d_rs1_used_i;
    assign w_d_u2   = d_valid_i && d_rs2_used_i;

    generate
        if (FWD_EN) begin : g_fwd
            // Only a load in E cannot be covered by forwarding.
            assign w_hazard = e_q.s.ld &&
                (f_match(e_q.s.valid, e_q.s.wr, e_q.s.rd, d_rs1_i, w_d_u1) ||
                 f_match(e_q.s.valid, e_q.s.wr, e_q.s.rd, d_rs2_i, w_d_u2));

            assign w_sel1 = f_match(m_q.valid, m_q.wr, m_q.rd, e_q.rs1, e_q.u1) ? c_sel_m :
                            f_match(w_q.valid, w_q.wr, w_q.rd, e_q.rs1, e_q.u1) ? c_sel_w :
                                                                                  c_sel_rf;
            assign w_sel2 = f_match(m_q.valid, m_q.wr, m_q.rd, e_q.rs2, e_q.u2) ? c_sel_m :
                            f_match(w_q.valid, w_q.wr, w_q.rd, e_q.rs2, e_q.u2) ? c_sel_w :
                                                                                  c_sel_rf;
        end else begin : g_ilk
            // No write-through regfile: wait until the producer has left W.
            assign w_hazard =
                f_match(e_q.s.valid, e_q.s.wr, e_q.s.rd, d_rs1_i, w_d_u1) ||
                f_match(e_q.s.valid, e_q.s.wr, e_q.s.rd, d_rs2_i, w_d_u2) ||
                f_match(m_q.valid,   m_q.wr,   m_q.rd,   d_rs1_i, w_d_u1) ||
                f_match(m_q.valid,   m_q.wr,   m_q.rd,   d_rs2_i, w_d_u2) ||
                f_match(w_q.valid,   w_q.wr,   w_q.rd,   d_rs1_i, w_d_u1) ||
                f_match(w_q.valid,   w_q.wr,   w_q.rd,   d_rs2_i, w_d_u2);

            assign w_sel1 = c_sel_rf;
            assign w_sel2 = c_sel_rf;
        end
    endgenerate

    assign freeze_o      = w_freeze;
    assign flush_fd_o    = !w_freeze && w_br;
    assign bubble_de_o   = !w_freeze && (w_br || w_hazard);
    assign stall_fd_o    = !w_freeze && !w_br && w_hazard;
    assign fwd_rs1_sel_o = w_sel1;
    assign fwd_rs2_sel_o = w_sel2;

    always_comb begin
        e_d   = e_q;
        m_d   = m_q;
        w_d   = w_q;
        cnt_d = cnt_q;
        if (w_freeze) begin
            w_d   = '0;
            cnt_d = cnt_q - 4'd1;
        end else begin
            w_d.valid   = m_q.valid;
            w_d.rd      = m_q.rd;
            w_d.wr      = m_q.wr;
            m_d         = e_q.s;
            e_d.s.valid = d_valid_i && !bubble_de_o;
            e_d.s.rd    = d_rd_i;
            e_d.s.wr    = d_regwren_i;
            e_d.s.ld    = d_memren_i;
            e_d.rs1     = d_rs1_i;
            e_d.rs2     = d_rs2_i;
            e_d.u1      = e_d.s.valid && d_rs1_used_i;
            e_d.u2      = e_d.s.valid && d_rs2_used_i;
            cnt_d       = (e_q.s.valid && e_q.s.ld && (c_lat != 4'd0)) ? c_lat : 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= 4'd0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire
